call_dispatcher: RTL



---
 rtl/call_dispatcher.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/call_dispatcher.sv
// call_dispatcher: front-end call conditioner and dispatcher for the elevator
// movement controller. Synchronises and debounces three call switches, latches
// pending calls, issues one buttonN pulse at a time and confirms arrival from
// the controller's floor/door/moving status before clearing the call.
// Optional build macro: CALL_CANCEL_EN (repeat press on a pending, non
// in-flight floor cancels that call).
module call_dispatcher #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call_in,
    input  logic       floor1,
    input  logic       floor2,
    input  logic       floor3,
    input  logic       door,
    input  logic       moving,
    input  logic       sos_mode,
    output logic       button1,
    output logic       button2,
    output logic       button3,
    output logic [2:0] pending,
    output logic       busy,
    output logic       arrived,
    output logic       timeout_err
);

    localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CNT_MAX = (PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MOVE,
        WAIT_ARRIVE,
        DOOR_HOLD
    } state_t;

    // input conditioning
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    level;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    rise;

    // floor decode and target selection
    logic [2:0] floor_vec;
    logic       cur_valid;
    logic [1:0] cur_idx;
    logic [1:0] order [3];
    logic [1:0] sel;
    logic       sel_found;
    logic [2:0] sel_mask;
    logic [2:0] tgt_mask;
    logic       at_target;

    // FSM
    state_t        state;
    state_t        state_next;
    logic [1:0]    target;
    logic [1:0]    target_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [2:0]    clr_mask;
    logic          arrive_evt;
    logic          timeout_evt;
    logic [2:0]    pending_next;

    assign floor_vec = {floor3, floor2, floor1};

    // Two-flop synchroniser on the raw switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= call_in;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the accepted level, aligned with the level update
    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            rise[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
        end
    end

    // Current floor index from the controller's one-hot status
    always_comb begin
        cur_valid = 1'b1;
        cur_idx   = 2'd0;
        case (floor_vec)
            3'b001:  cur_idx = 2'd0;
            3'b010:  cur_idx = 2'd1;
            3'b100:  cur_idx = 2'd2;
            default: cur_valid = 1'b0;
        endcase
    end

    // Nearest pending floor; ties go to the lower floor, unknown floor picks lowest
    always_comb begin
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
        if (cur_valid && cur_idx == 2'd1) begin
            order[0] = 2'd1;
            order[1] = 2'd0;
            order[2] = 2'd2;
        end else if (cur_valid && cur_idx == 2'd2) begin
            order[0] = 2'd2;
            order[1] = 2'd1;
            order[2] = 2'd0;
        end
        sel       = 2'd0;
        sel_found = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!sel_found && pending[order[k]]) begin
                sel       = order[k];
                sel_found = 1'b1;
            end
        end
        sel_mask  = 3'b001 << sel;
        tgt_mask  = 3'b001 << target;
        at_target = (floor_vec == tgt_mask) && !moving && door;
    end

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            target <= 2'd0;
            cnt    <= '0;
            timer  <= '0;
        end else begin
            state  <= state_next;
            target <= target_next;
            cnt    <= cnt_next;
            timer  <= timer_next;
        end
    end

    // FSM next-state, counters and event strobes
    always_comb begin
        state_next  = state;
        target_next = target;
        cnt_next    = cnt;
        timer_next  = timer;
        clr_mask    = '0;
        arrive_evt  = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                cnt_next   = '0;
                timer_next = '0;
                if (!sos_mode && pending != 3'b000) begin
                    target_next = sel;
                    if (cur_valid && sel == cur_idx && !moving) begin
                        clr_mask   = sel_mask;
                        arrive_evt = 1'b1;
                        state_next = DOOR_HOLD;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_next   = '0;
                    timer_next = '0;
                    state_next = WAIT_MOVE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            // The timeout window opens at ISSUE exit, so a car that never
            // starts moving is abandoned from here as well.
            WAIT_MOVE: begin
                if (moving || at_target) begin
                    timer_next = timer + 1'b1;
                    state_next = WAIT_ARRIVE;
                end else if (timer == TMO_LAST) begin
                    timer_next  = '0;
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            WAIT_ARRIVE: begin
                if (at_target) begin
                    clr_mask   = tgt_mask;
                    arrive_evt = 1'b1;
                    timer_next = '0;
                    cnt_next   = '0;
                    state_next = DOOR_HOLD;
                end else if (timer == TMO_LAST) begin
                    timer_next  = '0;
                    timeout_evt = 1'b1;
                    state_next  = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            DOOR_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state != IDLE && sos_mode) begin
            state_next  = IDLE;
            cnt_next    = '0;
            timer_next  = '0;
            clr_mask    = '0;
            arrive_evt  = 1'b0;
            timeout_evt = 1'b0;
        end
    end

`ifdef CALL_CANCEL_EN
    logic [2:0] inflight;
    logic [2:0] cancel;

    // Pending update with toggle-cancel on floors other than the in-flight target
    always_comb begin
        inflight     = (state != IDLE) ? tgt_mask : 3'b000;
        cancel       = rise & pending & ~inflight;
        pending_next = ((pending | rise) & ~cancel) & ~clr_mask;
    end
`else
    // Pending update: new presses latch, repeat presses are absorbed
    always_comb begin
        pending_next = (pending | rise) & ~clr_mask;
    end
`endif

    // Pending calls and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            arrived     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pending <= pending_next;
            arrived <= arrive_evt;
            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Button and busy decode from the registered state
    always_comb begin
        {button3, button2, button1} = (state == ISSUE) ? tgt_mask : 3'b000;
        busy                        = (state != IDLE);
    end

endmodule
